// File: rtl/stopwatch_lap_sequencer_pkg.sv
// Shared definitions for the stopwatch lap sequencer: the FSM state encoding
// and the {min, sec} layout of a time word.
package stopwatch_lap_sequencer_pkg;

  localparam int STATE_W = 3;

  localparam logic [STATE_W-1:0] ST_IDLE   = 3'd0;
  localparam logic [STATE_W-1:0] ST_RUN    = 3'd1;
  localparam logic [STATE_W-1:0] ST_LAP    = 3'd2;
  localparam logic [STATE_W-1:0] ST_PAUSE  = 3'd3;
  localparam logic [STATE_W-1:0] ST_RECALL = 3'd4;

  localparam int MIN_W   = 6;
  localparam int SEC_W   = 6;
  localparam int SEC_LSB = 0;
  localparam int MIN_LSB = SEC_W;
  localparam int FIELD_TIME_W = MIN_W + SEC_W;

  function automatic logic [MIN_W-1:0] time_min(input logic [FIELD_TIME_W-1:0] t);
    return t[MIN_LSB +: MIN_W];
  endfunction

  function automatic logic [SEC_W-1:0] time_sec(input logic [FIELD_TIME_W-1:0] t);
    return t[SEC_LSB +: SEC_W];
  endfunction

  function automatic logic [FIELD_TIME_W-1:0] pack_time(input logic [MIN_W-1:0] m,
                                                        input logic [SEC_W-1:0] s);
    return {m, s};
  endfunction

endpackage

// File: rtl/stopwatch_lap_sequencer_lap_ring_buffer.sv
// Circular store of captured lap times. Owns the write pointer and the
// saturating lap count; reads are by logical index with 0 = oldest entry.
module lap_ring_buffer #(
  parameter int LAP_DEPTH = 4,
  parameter int TIME_W    = 12,
  parameter int IDX_W     = $clog2(LAP_DEPTH),
  parameter int CNT_W     = $clog2(LAP_DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic              clr,
  input  logic [TIME_W-1:0] wr_data,
  input  logic [IDX_W-1:0]  rd_idx,
  output logic [TIME_W-1:0] rd_data,
  output logic [CNT_W-1:0]  lap_count
);

  logic [TIME_W-1:0] mem_q [LAP_DEPTH];
  logic [TIME_W-1:0] mem_d [LAP_DEPTH];
  logic [IDX_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [IDX_W-1:0]  oldest;
  logic [IDX_W-1:0]  rd_addr;
  logic              full;

  assign full = (count_q == CNT_W'(LAP_DEPTH));

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (clr) begin
      wr_ptr_d = '0;
      count_d  = '0;
    end else if (we) begin
      mem_d[wr_ptr_q] = wr_data;
      // Pointer width is exactly log2(LAP_DEPTH), so the increment wraps by itself.
      wr_ptr_d = wr_ptr_q + IDX_W'(1);
      if (!full) count_d = count_q + CNT_W'(1);
    end
  end

  // NOTE: the lap store is reset entry by entry because stored laps are
  // observable through recall and must read back as zero after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < LAP_DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Once the ring has wrapped, the next slot to be written holds the oldest lap.
  assign oldest    = full ? wr_ptr_q : '0;
  assign rd_addr   = oldest + rd_idx;
  assign rd_data   = mem_q[rd_addr];
  assign lap_count = count_q;

endmodule

// File: rtl/stopwatch_lap_sequencer.sv
// Mode sequencer for the stopwatch: turns button pulses into count/clear
// control, captures laps and selects the time word shown on the display.
module stopwatch_lap_sequencer
  import stopwatch_lap_sequencer_pkg::*;
#(
  parameter int LAP_DEPTH = 4,
  parameter int TIME_W    = 12
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           start_stop,
  input  logic                           lap_reset,
  input  logic                           recall,
  input  logic [TIME_W-1:0]              live_time,
  output logic                           count_en,
  output logic                           clear,
  output logic [TIME_W-1:0]              show_time,
  output logic                           lap_hold,
  output logic [$clog2(LAP_DEPTH+1)-1:0] lap_count,
  output logic [$clog2(LAP_DEPTH)-1:0]   lap_idx
);

  localparam int IDX_W = $clog2(LAP_DEPTH);
  localparam int CNT_W = $clog2(LAP_DEPTH + 1);

  logic [STATE_W-1:0] state_q, state_d;
  logic [TIME_W-1:0]  hold_q, hold_d;
  logic [TIME_W-1:0]  show_time_q, show_time_d;
  logic [IDX_W-1:0]   lap_idx_q, lap_idx_d;
  logic               count_en_q, count_en_d;
  logic               clear_q, clear_d;
  logic               lap_hold_q, lap_hold_d;

  logic               ev_start, ev_lap, ev_recall;
  logic               capture, wipe;
  logic [TIME_W-1:0]  recall_data;
  logic [CNT_W-1:0]   buf_count;
  logic               have_laps;
  logic               idx_last;

  // Same-cycle pulses resolve start_stop > lap_reset > recall; losers are dropped.
  assign ev_start  = start_stop;
  assign ev_lap    = lap_reset & ~start_stop;
  assign ev_recall = recall & ~start_stop & ~lap_reset;

  assign have_laps = (buf_count != '0);
  assign idx_last  = (CNT_W'(lap_idx_q) + CNT_W'(1) >= buf_count);

  lap_ring_buffer #(
    .LAP_DEPTH (LAP_DEPTH),
    .TIME_W    (TIME_W),
    .IDX_W     (IDX_W),
    .CNT_W     (CNT_W)
  ) u_ring (
    .clk       (clk),
    .rst_n     (rst_n),
    .we        (capture),
    .clr       (wipe),
    .wr_data   (live_time),
    .rd_idx    (lap_idx_d),
    .rd_data   (recall_data),
    .lap_count (buf_count)
  );

  // NOTE: every variable assigned in this block gets a default first, so no
  // path through the case can leave one unassigned and infer a latch.
  always_comb begin
    state_d   = state_q;
    lap_idx_d = lap_idx_q;
    capture   = 1'b0;
    wipe      = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (ev_start) begin
          state_d = ST_RUN;
        end else if (ev_recall && have_laps) begin
          state_d   = ST_RECALL;
          lap_idx_d = '0;
        end
      end
      ST_RUN: begin
        if (ev_start) begin
          state_d = ST_PAUSE;
        end else if (ev_lap) begin
          state_d = ST_LAP;
          capture = 1'b1;
        end
      end
      ST_LAP: begin
        if (ev_start)    state_d = ST_PAUSE;
        else if (ev_lap) state_d = ST_RUN;
      end
      ST_PAUSE: begin
        if (ev_start) begin
          state_d = ST_RUN;
        end else if (ev_lap) begin
          state_d = ST_IDLE;
          wipe    = 1'b1;
        end else if (ev_recall && have_laps) begin
          state_d   = ST_RECALL;
          lap_idx_d = '0;
        end
      end
      ST_RECALL: begin
        if (ev_start || ev_lap) begin
          state_d   = ST_PAUSE;
          lap_idx_d = '0;
        end else if (ev_recall) begin
          lap_idx_d = idx_last ? '0 : lap_idx_q + IDX_W'(1);
        end
      end
      default: begin
        state_d   = ST_IDLE;
        lap_idx_d = '0;
      end
    endcase
  end

  // Outputs are derived from the next state so that they register on the
  // same edge as the transition that causes them.
  always_comb begin
    hold_d      = capture ? live_time : hold_q;
    count_en_d  = (state_d == ST_RUN) || (state_d == ST_LAP);
    lap_hold_d  = (state_d == ST_LAP) || (state_d == ST_RECALL);
    clear_d     = wipe;
    show_time_d = live_time;
    if (state_d == ST_LAP)         show_time_d = hold_d;
    else if (state_d == ST_RECALL) show_time_d = recall_data;
  end

  // NOTE: state is updated with non-blocking assignments so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      hold_q      <= '0;
      show_time_q <= '0;
      lap_idx_q   <= '0;
      count_en_q  <= 1'b0;
      clear_q     <= 1'b0;
      lap_hold_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      hold_q      <= hold_d;
      show_time_q <= show_time_d;
      lap_idx_q   <= lap_idx_d;
      count_en_q  <= count_en_d;
      clear_q     <= clear_d;
      lap_hold_q  <= lap_hold_d;
    end
  end

  assign count_en  = count_en_q;
  assign clear     = clear_q;
  assign show_time = show_time_q;
  assign lap_hold  = lap_hold_q;
  assign lap_count = buf_count;
  assign lap_idx   = lap_idx_q;

endmodule

// File: tb/tb_stopwatch_lap_sequencer.sv
// Directed bench for stopwatch_lap_sequencer: hand-computed expectations for
// reset, lap freeze, ring overwrite, clear, pulse priority and async reset.
module tb_stopwatch_lap_sequencer;
  import stopwatch_lap_sequencer_pkg::*;

  localparam int LAP_DEPTH = 4;
  localparam int TIME_W    = 12;

  logic              clk;
  logic              rst_n;
  logic              start_stop;
  logic              lap_reset;
  logic              recall;
  logic [TIME_W-1:0] live_time;
  logic              count_en;
  logic              clear;
  logic [TIME_W-1:0] show_time;
  logic              lap_hold;
  logic [2:0]        lap_count;
  logic [1:0]        lap_idx;

  int n_tests = 0;
  int n_fail  = 0;

  stopwatch_lap_sequencer #(
    .LAP_DEPTH (LAP_DEPTH),
    .TIME_W    (TIME_W)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start_stop (start_stop),
    .lap_reset  (lap_reset),
    .recall     (recall),
    .live_time  (live_time),
    .count_en   (count_en),
    .clear      (clear),
    .show_time  (show_time),
    .lap_hold   (lap_hold),
    .lap_count  (lap_count),
    .lap_idx    (lap_idx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Inputs change on the falling edge; the task returns on the falling edge
  // after the rising edge that consumed the pulse, so outputs are settled.
  task automatic pulse(input logic ss, input logic lr, input logic rc);
    @(negedge clk);
    start_stop = ss;
    lap_reset  = lr;
    recall     = rc;
    @(negedge clk);
    start_stop = 1'b0;
    lap_reset  = 1'b0;
    recall     = 1'b0;
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".count_en"},  32'(count_en),  32'h0);
    check({tag, ".clear"},     32'(clear),     32'h0);
    check({tag, ".show_time"}, 32'(show_time), 32'h0);
    check({tag, ".lap_hold"},  32'(lap_hold),  32'h0);
    check({tag, ".lap_count"}, 32'(lap_count), 32'h0);
    check({tag, ".lap_idx"},   32'(lap_idx),   32'h0);
  endtask

  logic [TIME_W-1:0] exp_show [5];
  logic [1:0]        exp_idx  [5];

  initial begin
    rst_n      = 1'b0;
    start_stop = 1'b0;
    lap_reset  = 1'b0;
    recall     = 1'b0;
    live_time  = 12'h0AB;

    // 1: pulses during reset are ignored, then start runs
    tick(1);
    pulse(1'b1, 1'b0, 1'b1);
    pulse(1'b0, 1'b1, 1'b0);
    check_all_zero("rst_held");
    rst_n     = 1'b1;
    live_time = 12'h010;
    tick(1);
    check("idle.count_en", 32'(count_en), 32'h0);
    pulse(1'b1, 1'b0, 1'b0);
    check("run.count_en",  32'(count_en),  32'h1);
    check("run.show_live", 32'(show_time), 32'h010);
    check("run.lap_hold",  32'(lap_hold),  32'h0);

    // 2: lap freezes 3:05 while live moves on
    live_time = pack_time(6'd3, 6'd5);
    pulse(1'b0, 1'b1, 1'b0);
    check("lap.show",      32'(show_time), 32'h0C5);
    check("lap.hold",      32'(lap_hold),  32'h1);
    check("lap.count",     32'(lap_count), 32'h1);
    check("lap.count_en",  32'(count_en),  32'h1);
    live_time = 12'h0C6;
    tick(2);
    check("lap.frozen",    32'(show_time), 32'h0C5);
    pulse(1'b0, 1'b1, 1'b0);
    check("unlap.show",    32'(show_time), 32'h0C6);
    check("unlap.hold",    32'(lap_hold),  32'h0);
    check("unlap.count",   32'(lap_count), 32'h1);
    live_time = 12'h0C7;
    tick(1);
    check("run.tracks",    32'(show_time), 32'h0C7);

    // 5: start_stop beats lap_reset in RUN: pause, no capture
    pulse(1'b1, 1'b1, 1'b0);
    check("prio.count_en", 32'(count_en),  32'h0);
    check("prio.hold",     32'(lap_hold),  32'h0);
    check("prio.count",    32'(lap_count), 32'h1);
    check("prio.clear",    32'(clear),     32'h0);

    // 4: lap_reset in PAUSE clears for one cycle and empties the buffer
    pulse(1'b0, 1'b1, 1'b0);
    check("clr.clear",     32'(clear),     32'h1);
    check("clr.count",     32'(lap_count), 32'h0);
    check("clr.count_en",  32'(count_en),  32'h0);
    tick(1);
    check("clr.one_cycle", 32'(clear),     32'h0);
    live_time = 12'h111;
    pulse(1'b0, 1'b0, 1'b1);
    check("idle.recall_ignored", 32'(lap_hold),  32'h0);
    check("idle.show_live",      32'(show_time), 32'h111);
    pulse(1'b0, 1'b1, 1'b0);
    check("idle.lr_no_clear",    32'(clear),     32'h0);
    check("idle.lr_count_en",    32'(count_en),  32'h0);

    // 3: five laps at 1..5 s into a four-deep ring
    pulse(1'b1, 1'b0, 1'b0);
    check("run2.count_en", 32'(count_en), 32'h1);
    for (int i = 1; i <= 5; i++) begin
      live_time = TIME_W'(i);
      pulse(1'b0, 1'b1, 1'b0);
      check($sformatf("cap%0d.show", i),  32'(show_time), 32'(i));
      check($sformatf("cap%0d.count", i), 32'(lap_count), 32'((i > 4) ? 4 : i));
      pulse(1'b0, 1'b1, 1'b0);
    end
    live_time = pack_time(6'd1, 6'd0);
    pulse(1'b1, 1'b0, 1'b0);
    check("pause.show",     32'(show_time), 32'h040);
    check("pause.count_en", 32'(count_en),  32'h0);
    check("pause.count",    32'(lap_count), 32'h4);

    exp_show = '{12'h002, 12'h003, 12'h004, 12'h005, 12'h002};
    exp_idx  = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    for (int i = 0; i < 5; i++) begin
      pulse(1'b0, 1'b0, 1'b1);
      check($sformatf("rcl%0d.show", i), 32'(show_time), 32'(exp_show[i]));
      check($sformatf("rcl%0d.idx", i),  32'(lap_idx),   32'(exp_idx[i]));
      check($sformatf("rcl%0d.hold", i), 32'(lap_hold),  32'h1);
    end
    check("rcl.count_en", 32'(count_en), 32'h0);

    // lap_reset leaves RECALL for PAUSE without clearing anything
    pulse(1'b0, 1'b0, 1'b1);
    check("rcl.idx_before_exit", 32'(lap_idx), 32'h1);
    pulse(1'b0, 1'b1, 1'b0);
    check("rcl_exit.idx",   32'(lap_idx),   32'h0);
    check("rcl_exit.hold",  32'(lap_hold),  32'h0);
    check("rcl_exit.clear", 32'(clear),     32'h0);
    check("rcl_exit.count", 32'(lap_count), 32'h4);
    check("rcl_exit.show",  32'(show_time), 32'h040);
    pulse(1'b0, 1'b0, 1'b1);
    check("rcl_again.show", 32'(show_time), 32'h002);

    // 6: asynchronous reset mid-cycle while recalling
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_all_zero("async_rst");
    @(negedge clk);
    rst_n = 1'b1;
    live_time = 12'h222;
    pulse(1'b0, 1'b0, 1'b1);
    check("post_rst.recall_ignored", 32'(lap_hold),  32'h0);
    check("post_rst.show",           32'(show_time), 32'h222);
    pulse(1'b1, 1'b0, 1'b0);
    check("post_rst.run",            32'(count_en),  32'h1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
